// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-FU one-entry holding buffers granted round-robin onto a 3-wide CDB.
// Optional build macro CDB_STALL_CNT_EN adds a saturating stall_cycles counter output.
module cdb_arbiter #(
  parameter int NUM_FU = 6,
  parameter int XLEN   = 32,
  parameter int PR     = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [NUM_FU-1:0]            fu_valid,
  input  logic [NUM_FU-1:0][PR-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]  fu_data,
  output logic [NUM_FU-1:0]            fu_ready,
  output logic [2:0]                   cdb_valid,
  output logic [2:0][PR-1:0]           cdb_tag,
  output logic [2:0][XLEN-1:0]         cdb_data
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int            LANES   = 3;
  localparam int            PW      = $clog2(NUM_FU);
  localparam logic [PR-1:0] ZERO_PR = '0;

  logic [NUM_FU-1:0]           buf_valid;
  logic [NUM_FU-1:0][PR-1:0]   buf_tag;
  logic [NUM_FU-1:0][XLEN-1:0] buf_data;
  logic [PW-1:0]               rr_ptr;
  logic [PW-1:0]               next_ptr;
  logic [NUM_FU-1:0]           grant;
  logic [LANES-1:0]            lane_valid;
  logic [LANES-1:0][PW-1:0]    lane_idx;
  logic [NUM_FU-1:0]           accept;
  int                          scan_idx;
  int                          lane_cnt;
  int                          valid_cnt;

  // Round-robin scan starting at rr_ptr; the first three valid buffers fill lanes 0..2.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    next_ptr   = rr_ptr;
    scan_idx   = 0;
    lane_cnt   = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      scan_idx = int'(rr_ptr) + j;
      if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
      if (buf_valid[scan_idx] && lane_cnt < LANES) begin
        grant[scan_idx]      = 1'b1;
        lane_valid[lane_cnt] = 1'b1;
        lane_idx[lane_cnt]   = PW'(scan_idx);
        next_ptr             = (scan_idx == NUM_FU - 1) ? '0 : PW'(scan_idx + 1);
        lane_cnt             = lane_cnt + 1;
      end
    end
  end

  always_comb begin
    fu_ready = squash ? '0 : (~buf_valid | grant);
    accept   = fu_valid & fu_ready;
    for (int k = 0; k < LANES; k++) begin
      cdb_valid[k] = lane_valid[k] & ~squash;
      cdb_tag[k]   = cdb_valid[k] ? buf_tag[lane_idx[k]]  : ZERO_PR;
      cdb_data[k]  = cdb_valid[k] ? buf_data[lane_idx[k]] : '0;
    end
  end

  // A load in the same cycle as a grant wins; a zero-tag result is consumed but never buffered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      buf_valid <= '0;
      rr_ptr    <= '0;
    end else if (squash) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i])     buf_valid[i] <= (fu_tag[i] != ZERO_PR);
        else if (grant[i]) buf_valid[i] <= 1'b0;
      end
      if (|grant) rr_ptr <= next_ptr;
    end
  end

  // NOTE: payload storage has no reset; buf_valid alone qualifies it, which keeps these plain flops.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        buf_tag[i]  <= fu_tag[i];
        buf_data[i] <= fu_data[i];
      end
    end
  end

  always_comb begin
    valid_cnt = 0;
    for (int i = 0; i < NUM_FU; i++) valid_cnt = valid_cnt + int'(buf_valid[i]);
  end

`ifdef CDB_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (valid_cnt > LANES && !squash && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scoreboard of expected CDB results plus directed checks.
// Build with CDB_STALL_CNT_EN defined to also check the stall counter.
module tb_cdb_arbiter;

  localparam int NUM_FU = 6;
  localparam int XLEN   = 32;
  localparam int PR     = 6;

  typedef struct {
    logic [PR-1:0]   tag;
    logic [XLEN-1:0] data;
  } exp_t;

  logic                        clock;
  logic                        reset;
  logic                        squash;
  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU-1:0][PR-1:0]   fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0] fu_data;
  logic [NUM_FU-1:0]           fu_ready;
  logic [2:0]                  cdb_valid;
  logic [2:0][PR-1:0]          cdb_tag;
  logic [2:0][XLEN-1:0]        cdb_data;
`ifdef CDB_STALL_CNT_EN
  logic [31:0]                 stall_cycles;
`endif

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .PR(PR)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every CDB lane against the scoreboard; invalid lanes must be packed high and idle.
  task automatic monitor();
    logic seen_invalid;
    exp_t e;
    seen_invalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (cdb_valid[k]) begin
        if (seen_invalid) check("lane_packed", cdb_valid[k], 0);
        if (sb.size() == 0) begin
          check("cdb_unexpected", cdb_valid[k], 0);
        end else begin
          e = sb.pop_front();
          check("cdb_tag", cdb_tag[k], e.tag);
          check("cdb_data", cdb_data[k], e.data);
        end
      end else begin
        seen_invalid = 1'b1;
        check("idle_tag", cdb_tag[k], 0);
        check("idle_data", cdb_data[k], 0);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    monitor();
  endtask

  task automatic send(input int fu, input int tag, input logic [XLEN-1:0] data);
    exp_t e;
    fu_valid[fu] = 1'b1;
    fu_tag[fu]   = PR'(tag);
    fu_data[fu]  = data;
    if (tag != 0) begin
      e.tag  = PR'(tag);
      e.data = data;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
    #12;
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_tag", cdb_tag, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_fu_ready", fu_ready, 6'h3F);
`ifdef CDB_STALL_CNT_EN
    check("rst_stall", stall_cycles, 0);
`endif

    // Single result from FU2, then rr_ptr=3 puts FU4 ahead of FU0.
    do_reset();
    next_cycle(); send(2, 5, 32'hDEAD); sample();
    next_cycle(); fu_valid = '0; sample();
    check("single_lanes", cdb_valid, 3'b001);
    next_cycle(); sample();
    check("single_rr", dut.rr_ptr, 3);
    next_cycle(); send(4, 8, 32'h4444); send(0, 7, 32'h0000_1111); sample();
    next_cycle(); fu_valid = '0; sample();
    check("rr_order_lanes", cdb_valid, 3'b011);
    check("single_drained", sb.size(), 0);

    // Oversubscription: six results at once.
    do_reset();
    next_cycle();
    for (int i = 0; i < NUM_FU; i++) send(i, i + 1, 32'h100 + i);
    sample();
    next_cycle(); fu_valid = '0; sample();
    check("os_c2_valid", cdb_valid, 3'b111);
    check("os_c2_ready", fu_ready, 6'b000111);
    next_cycle(); sample();
    check("os_c3_valid", cdb_valid, 3'b111);
    check("os_c3_ready", fu_ready, 6'h3F);
`ifdef CDB_STALL_CNT_EN
    check("os_stall", stall_cycles, 1);
`endif
    next_cycle(); sample();
    check("os_idle", cdb_valid, 0);
    check("os_drained", sb.size(), 0);

    // Fairness: FU0 and FU5 stream every cycle.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      send(0, 1 + c, 32'hA000 + c);
      send(5, 32 + c, 32'hB000 + c);
      sample();
      check("fair_ready", {fu_ready[5], fu_ready[0]}, 2'b11);
      if (c > 0) check("fair_lanes", cdb_valid, 3'b011);
    end
    next_cycle(); fu_valid = '0; sample();
    next_cycle(); sample();
    check("fair_drained", sb.size(), 0);

    // Zero tag is consumed and never buffered.
    do_reset();
    next_cycle(); send(1, 0, 32'h55); sample();
    check("zero_ready", fu_ready[1], 1);
    for (int c = 0; c < 2; c++) begin
      next_cycle(); fu_valid = '0; sample();
      check("zero_cdb", cdb_valid, 0);
      check("zero_buf", dut.buf_valid[1], 0);
    end

    // Squash with four buffers full; rr_ptr moved to 2 beforehand.
    do_reset();
    next_cycle(); send(1, 20, 32'h2020); sample();
    next_cycle();
    fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i]   = PR'(10 + i);
      fu_data[i]  = 32'hC000 + i;
    end
    sample();
    next_cycle(); fu_valid = '0; squash = 1'b1;
    @(negedge clock);
    check("sq_cdb", cdb_valid, 0);
    check("sq_ready", fu_ready, 0);
    next_cycle(); squash = 1'b0; sample();
    check("sq_next_cdb", cdb_valid, 0);
    check("sq_next_ready", fu_ready, 6'h3F);
    check("sq_rr", dut.rr_ptr, 2);
`ifdef CDB_STALL_CNT_EN
    check("sq_stall", stall_cycles, 0);
`endif
    check("sq_drained", sb.size(), 0);

    // Async reset mid-cycle with three buffers full.
    do_reset();
    next_cycle(); send(1, 21, 32'h2121); sample();
    next_cycle();
    fu_valid = '0;
    fu_valid[0] = 1'b1; fu_tag[0] = 6'd30; fu_data[0] = 32'h3030;
    fu_valid[2] = 1'b1; fu_tag[2] = 6'd31; fu_data[2] = 32'h3131;
    fu_valid[3] = 1'b1; fu_tag[3] = 6'd32; fu_data[3] = 32'h3232;
    sample();
    next_cycle(); fu_valid = '0;
    check("ar_pre_cdb", cdb_valid, 3'b111);
    #2; reset = 1'b0; #1;
    check("ar_cdb", cdb_valid, 0);
    check("ar_tag", cdb_tag, 0);
    check("ar_ready", fu_ready, 6'h3F);
    @(negedge clock); reset = 1'b1;
    next_cycle(); sample();
    check("ar_rr", dut.rr_ptr, 0);
    check("ar_after_cdb", cdb_valid, 0);

    check("final_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter between the functional units and the 3-wide CDB / physical register file write ports. Each FU result is captured in a one-entry holding buffer. Each cycle up to 3 buffered results are granted in round-robin order onto CDB lanes 0..2. The lanes drive the PRF write index/data and the wakeup/complete tag broadcast. Backpressure to each FU goes through a per-FU valid/ready handshake.

## Interface
- `NUM_FU`, 6, number of requesting functional units (4..8)
- `XLEN`, 32, result data width
- `PR`, 6, physical register tag width; tag 0 is the zero register (`ZERO_PR`)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `squash`  in  1  mispredict flush; clears all buffers
- `fu_valid`  in  NUM_FU  FU i presents a result
- `fu_tag`  in  NUM_FU×PR  destination physical tag
- `fu_data`  in  NUM_FU×XLEN  result value
- `fu_ready`  out  NUM_FU  FU i result accepted this cycle when valid&ready
- `cdb_valid`  out  3  lane k carries a result
- `cdb_tag`  out  3×PR  lane k tag (lane 0 = t0, 1 = t1, 2 = t2); `ZERO_PR` when lane invalid
- `cdb_data`  out  3×XLEN  lane k data; 0 when lane invalid

## Operation
- State: per-FU `buf_valid`, `buf_tag`, `buf_data`; round-robin pointer `rr_ptr` (0..NUM_FU-1).
- Grant:
  - Scan buffers starting at `rr_ptr`, wrapping modulo NUM_FU.
  - The first 3 valid buffers are granted, in scan order, to lanes 0, 1, 2.
  - Unused lanes are invalid. Lanes are always packed low: no valid lane above an invalid one.
- `fu_ready[i] = !buf_valid[i] | grant[i]`, forced 0 while `squash`. It does not depend on `fu_valid`.
- Buffer update each edge, per FU:
  - A grant clears the buffer.
  - An accepted result (`fu_valid & fu_ready`) loads the buffer.
  - If both happen, the load wins.
- Accepted result with `fu_tag == 0` is consumed (ready asserted) but not buffered; it never appears on the CDB.
- `rr_ptr` update:
  - If any grant: `rr_ptr <= (index of last granted FU + 1) mod NUM_FU`.
  - If no grant: unchanged.
- `squash`:
  - All `buf_valid` clear at the next edge.
  - `cdb_valid` is forced 0 in the squash cycle.
  - Incoming results are not accepted.
  - `rr_ptr` is unchanged.
- Async reset: all `buf_valid` = 0, `rr_ptr` = 0. Outputs then read `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `fu_ready` = all 1s.

## Timing
- Latency: result accepted at edge N is eligible on CDB in cycle N+1 at the earliest. CDB outputs are combinational from buffer state and are registered downstream by the PRF.
- Throughput: 1 result per FU per cycle sustained when granted, because ready is re-asserted in the grant cycle.
- Starvation bound: any valid buffer is granted within ceil(NUM_FU/3) cycles, absent squash.
- Reset deassertion is synchronised externally; the first usable edge is the one after `reset` rises.
- Reset mid-operation: buffered results are discarded immediately, with no CDB output.

## Configuration
- `CDB_STALL_CNT_EN`: when defined, adds output `stall_cycles`, 32 bits.
  - Increments on every cycle in which more than 3 buffers are valid and `squash` is low.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- When undefined, the port and counter are absent. Arbitration behaviour is identical either way.

## Test plan
- Single result: FU2 sends tag 5, data 0xDEAD at edge 1 → cycle 2: lane0 valid, tag 5, data 0xDEAD; lanes 1–2 invalid with tag 0; `rr_ptr` = 3 after edge 2.
- Oversubscription: all 6 FUs valid with tags 1..6 from reset, FUs driving nothing after acceptance.
  - Cycle 2: lanes carry tags 1, 2, 3.
  - Cycle 3: lanes carry tags 4, 5, 6.
  - `fu_ready[3..5]` stays 0 during cycle 2.
  - With the macro defined, `stall_cycles` = 1.
- Fairness: FU0 and FU5 valid every cycle with NUM_FU = 6 → both granted every cycle, and each `fu_ready` stays 1 continuously.
- Zero tag: FU1 sends tag 0 → `fu_ready[1]` = 1, no CDB lane ever valid, `buf_valid[1]` stays 0.
- Squash with 4 buffers full → squash cycle shows `cdb_valid` = 0 and `fu_ready` = 0; next cycle `cdb_valid` = 0 and `fu_ready` = all 1s; `rr_ptr` unchanged.
- Async reset asserted mid-cycle with 3 buffers full → `cdb_valid` drops to 0 without a clock edge; `rr_ptr` = 0 after release.
